// File: rtl/soc_ram.sv
// soc_ram: dual-bank (IRAM/DRAM) byte-writable RAM with registered tri-state read buses
module soc_ram_bank #(
    parameter int               XLEN  = 32,
    parameter logic [XLEN-1:0]  BASE  = '0,
    parameter int               WORDS = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [XLEN-1:0]     rd_addr,
    input  logic [XLEN-1:0]     wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [XLEN/8-1:0]   wr_byte_en,
    inout  wire logic [XLEN-1:0] rd_data
);
    localparam int NB = XLEN / 8;
    localparam int AW = $clog2(WORDS);
    localparam int BW = $clog2(NB);
    localparam logic [XLEN:0] SPAN = (XLEN+1)'(WORDS * NB);
    logic [XLEN-1:0] mem [WORDS];
    logic [XLEN-1:0] rd_off, wr_off, rd_q;
    logic            rd_hit, wr_hit, hit_q;
    assign rd_off = rd_addr - BASE;
    assign wr_off = wr_addr - BASE;
    // Subtraction wraps below BASE, so the lower bound is checked explicitly
    assign rd_hit = (rd_addr >= BASE) && ({1'b0, rd_off} < SPAN);
    assign wr_hit = (wr_addr >= BASE) && ({1'b0, wr_off} < SPAN);
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NB; i++)
            if (wr_hit && wr_byte_en[i]) mem[wr_off[BW +: AW]][8*i +: 8] <= wr_data[8*i +: 8];
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            hit_q <= 1'b0;
        end else begin
            rd_q  <= mem[rd_off[BW +: AW]];
            hit_q <= rd_hit;
        end
    end
    assign rd_data = hit_q ? rd_q : 'z;
endmodule

module soc_ram #(
    parameter int               XLEN       = 32,
    parameter logic [XLEN-1:0]  IRAM_BASE  = 32'h0000_0000,
    parameter int               IRAM_WORDS = 4096,
    parameter logic [XLEN-1:0]  DRAM_BASE  = 32'h1000_0000,
    parameter int               DRAM_WORDS = 4096
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [XLEN-1:0]      iram_rd_addr_i,
    input  logic [XLEN-1:0]      iram_wr_addr_i,
    input  logic [XLEN-1:0]      iram_wr_data_i,
    input  logic [XLEN/8-1:0]    iram_wr_byte_en_i,
    input  logic [XLEN-1:0]      dram_rd_addr_i,
    input  logic [XLEN-1:0]      dram_wr_addr_i,
    input  logic [XLEN-1:0]      dram_wr_data_i,
    input  logic [XLEN/8-1:0]    dram_wr_byte_en_i,
    inout  wire logic [XLEN-1:0] iram_rd_data_io,
    inout  wire logic [XLEN-1:0] dram_rd_data_io
);
    soc_ram_bank #(.XLEN(XLEN), .BASE(IRAM_BASE), .WORDS(IRAM_WORDS)) u_iram (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr(iram_rd_addr_i), .wr_addr(iram_wr_addr_i),
        .wr_data(iram_wr_data_i), .wr_byte_en(iram_wr_byte_en_i),
        .rd_data(iram_rd_data_io)
    );
    soc_ram_bank #(.XLEN(XLEN), .BASE(DRAM_BASE), .WORDS(DRAM_WORDS)) u_dram (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd_addr(dram_rd_addr_i), .wr_addr(dram_wr_addr_i),
        .wr_data(dram_wr_data_i), .wr_byte_en(dram_wr_byte_en_i),
        .rd_data(dram_rd_data_io)
    );
endmodule

// File: tb/tb_soc_ram.sv
// tb_soc_ram: table-driven check of soc_ram reads, writes, windows and reset
module tb_soc_ram;
    logic        clk = 0;
    logic        rst;
    logic [31:0] ira, iwa, iwd, dra, dwa, dwd;
    logic [3:0]  ibe, dbe;
    logic        iext_en, dext_en;
    logic [31:0] iext, dext;
    wire  [31:0] ibus, dbus;
    int          checks = 0, errors = 0;

    // External slaves stand in for the DUT whenever it should release the bus
    assign ibus = iext_en ? iext : 'z;
    assign dbus = dext_en ? dext : 'z;

    soc_ram dut (
        .clk_i(clk), .rst_i(rst),
        .iram_rd_addr_i(ira), .iram_wr_addr_i(iwa), .iram_wr_data_i(iwd), .iram_wr_byte_en_i(ibe),
        .dram_rd_addr_i(dra), .dram_wr_addr_i(dwa), .dram_wr_data_i(dwd), .dram_wr_byte_en_i(dbe),
        .iram_rd_data_io(ibus), .dram_rd_data_io(dbus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ira, iwa, iwd; logic [3:0] ibe; logic iz; logic [31:0] iexp;
        logic [31:0] dra, dwa, dwd; logic [3:0] dbe; logic dz; logic [31:0] dexp;
    } vec_t;

    localparam logic [31:0] IN = 32'h0000_4000, DN = 32'h2000_0000, D = 32'h1000_0000;
    vec_t v [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        iwa = 0; iwd = 0; ibe = 0; dwa = 0; dwd = 0; dbe = 0;
        iext_en = 0; dext_en = 0; iext = 0; dext = 0;
    endtask

    initial begin
        v[0]  = '{IN, 32'h4, 32'hCC55AA55, 4'hF, 1'b1, 32'h0,
                  DN, D+32'h10, 32'h0D0C0B01, 4'hF, 1'b1, 32'h0};
        v[1]  = '{32'h4, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCC55AA55,
                  D+32'h10, D+32'h10, 32'hFFFFFFFF, 4'h5, 1'b0, 32'h0D0C0B01};
        v[2]  = '{32'h5, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCC55AA55,
                  D+32'h10, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0DFF0BFF};
        v[3]  = '{32'h7, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCC55AA55,
                  DN, D, 32'h00009BF2, 4'hF, 1'b1, 32'h12345678};
        v[4]  = '{IN, 32'h3FFC, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0,
                  D, D, 32'h01742023, 4'hF, 1'b0, 32'h00009BF2};
        v[5]  = '{32'h3FFC, 32'h0, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF,
                  D, DN, 32'hAAAAAAAA, 4'hF, 1'b0, 32'h01742023};
        v[6]  = '{IN, IN, 32'h55555555, 4'hF, 1'b1, 32'h0,
                  D, 32'h0, 32'h0, 4'h0, 1'b0, 32'h01742023};
        v[7]  = '{IN, 32'h8, 32'h11111111, 4'hF, 1'b1, 32'h0,
                  D, D+32'h8, 32'h22222222, 4'hF, 1'b0, 32'h01742023};
        v[8]  = '{32'h8, 32'h0, 32'h0, 4'h0, 1'b0, 32'h11111111,
                  D+32'h8, 32'h0, 32'h0, 4'h0, 1'b0, 32'h22222222};
        v[9]  = '{32'h4, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCC55AA55,
                  D+32'h10, D+32'h3FFC, 32'hA5A55A5A, 4'hF, 1'b0, 32'h0DFF0BFF};
        v[10] = '{32'h8, 32'h4, 32'h0, 4'h0, 1'b0, 32'h11111111,
                  D+32'h3FFC, D+32'h8, 32'hFFFFFFFF, 4'h0, 1'b0, 32'hA5A55A5A};
        v[11] = '{32'h4, 32'h0, 32'h0, 4'h0, 1'b0, 32'hCC55AA55,
                  D+32'h8, 32'h0, 32'h0, 4'h0, 1'b0, 32'h22222222};
        v[12] = '{32'h0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h600DF00D,
                  32'h0FFFFFFC, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0};

        // Reset with in-window reads: buses released; a write during reset still lands
        idle();
        rst = 1; ira = 32'h0; dra = D;
        iwa = 32'h0; iwd = 32'h600DF00D; ibe = 4'hF;
        iext_en = 1; dext_en = 1;
        tick();
        chk("rst_iram_z_c1", ibus, 32'h0);
        chk("rst_dram_z_c1", dbus, 32'h0);
        ibe = 0;
        tick();
        chk("rst_iram_z_c2", ibus, 32'h0);
        chk("rst_dram_z_c2", dbus, 32'h0);
        rst = 0; iext_en = 0; dext_en = 0;
        dra = DN; dext_en = 1;
        tick();
        chk("post_rst_iram0", ibus, 32'h600DF00D);

        for (int k = 0; k < 13; k++) begin
            ira = v[k].ira; iwa = v[k].iwa; iwd = v[k].iwd; ibe = v[k].ibe;
            dra = v[k].dra; dwa = v[k].dwa; dwd = v[k].dwd; dbe = v[k].dbe;
            iext_en = v[k].iz; iext = v[k].iexp;
            dext_en = v[k].dz; dext = v[k].dexp;
            tick();
            chk($sformatf("vec%0d_iram", k), ibus, v[k].iexp);
            chk($sformatf("vec%0d_dram", k), dbus, v[k].dexp);
        end

        // Reset in the middle of a read stream discards the pending word
        idle();
        ira = 32'h8; dra = D + 32'h8;
        tick();
        chk("mid_pre_iram", ibus, 32'h11111111);
        chk("mid_pre_dram", dbus, 32'h22222222);
        rst = 1; iext_en = 1; dext_en = 1;
        tick();
        chk("mid_rst_iram_z", ibus, 32'h0);
        chk("mid_rst_dram_z", dbus, 32'h0);
        rst = 0; iext_en = 0; dext_en = 0;
        tick();
        chk("mid_post_iram", ibus, 32'h11111111);
        chk("mid_post_dram", dbus, 32'h22222222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soc_ram.md
Name: soc_ram

Overview:
- Dual-bank on-chip memory for the hxd32 SoC: one instruction RAM (IRAM) and one data RAM (DRAM).
- Each bank has one read port and one byte-enabled write port.
- Read data is returned on shared tri-state buses, so other bus slaves (the UART peripheral, the loader) can sit on the same DRAM read bus.
- Clients are the CPU core and the UART loader/debugger (ram_rw).

Parameters:
- XLEN, 32, data/address width in bits; must be a multiple of 8.
- IRAM_BASE, 32'h0000_0000, byte base address of the IRAM window.
- IRAM_WORDS, 4096, IRAM depth in XLEN-bit words; power of two.
- DRAM_BASE, 32'h1000_0000, byte base address of the DRAM window.
- DRAM_WORDS, 4096, DRAM depth in XLEN-bit words; power of two.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- iram_rd_addr_i  input  XLEN  IRAM read byte address.
- iram_wr_addr_i  input  XLEN  IRAM write byte address.
- iram_wr_data_i  input  XLEN  IRAM write data.
- iram_wr_byte_en_i  input  XLEN/8  IRAM byte write enables; 0 = no write.
- dram_rd_addr_i  input  XLEN  DRAM read byte address.
- dram_wr_addr_i  input  XLEN  DRAM write byte address.
- dram_wr_data_i  input  XLEN  DRAM write data.
- dram_wr_byte_en_i  input  XLEN/8  DRAM byte write enables.
- iram_rd_data_io  inout  XLEN  IRAM read data; tri-state.
- dram_rd_data_io  inout  XLEN  DRAM read data; tri-state, shared with other slaves.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Addressing:
  - Byte addresses; addr[1:0] (log2(XLEN/8) LSBs) ignored, no misalignment handling.
  - Word index = (addr - BASE) >> 2.
- Window hit: BASE <= addr < BASE + WORDS*XLEN/8, evaluated per port.
- Writes:
  - On a rising edge with hit and byte_en[i]=1, byte i of the addressed word takes wr_data[8i+7:8i].
  - Unset bytes are unchanged.
  - Out-of-window writes are ignored silently.
  - byte_en = 0 means no write.
- Reads:
  - Synchronous, 1-cycle latency: address sampled at edge N, data valid after edge N.
  - The data register and a hit flag are both registered.
  - Port drives rd_data_io with the registered word when its registered hit flag = 1, else drives all-Z.
  - This lets the UART and other slaves drive dram_rd_data_io for their own address ranges.
- Read-during-write to the same word in the same bank and cycle: read-first, i.e. returns old contents; the new data is visible on the next read.
- IRAM and DRAM are fully independent; simultaneous read+write on both banks in one cycle is supported.
- Reset:
  - rst_i=1 at an edge clears both read data registers to 0 and both hit flags to 0, so both buses are Z during and right after reset.
  - Memory contents are not cleared.
  - A write presented in the same cycle as reset is still performed.
- Memory contents are undefined at power-up (X in sim); optional zero-init is allowed, but benches must not rely on it.
- Reset asserted mid-read: the pending read result is discarded and the bus goes Z.
- Reads resume the cycle after rst_i deasserts.
- No combinational path from any input to the rd_data_io outputs, except through the tri-state enable register.
- Target implementation: inferable block RAM, with byte-enable write loops per bank.

Test Plan:
- Reset: rst_i=1 for 2 cycles with addresses in-window -> both rd_data_io = Z; after release, a read of IRAM 0x0 returns the stored word one cycle later.
- Full-word write/read: IRAM write addr 0x4, data 0xCC55AA55, byte_en 4'hF; next cycle read 0x4 -> 0xCC55AA55 after 1 edge; also reading 0x5 or 0x7 returns the same word.
- Byte enables:
  - DRAM 0x1000_0010 write 0x0D0C0B01 with en 4'hF.
  - Then write 0xFFFFFFFF with en 4'b0101.
  - Read -> 0x0DFF0BFF.
- Window decode:
  - dram_rd_addr 0x2000_0000 -> dram_rd_data_io = Z.
  - Write to 0x2000_0000 leaves all DRAM words unchanged.
  - External driver 0x12345678 on the bus is read back cleanly with no contention.
- Read-during-write: DRAM word holds 0x00009BF2; same cycle write 0x01742023 en 4'hF and read same addr -> 0x00009BF2, next read -> 0x01742023.
- Bank independence: simultaneous IRAM write 0x11111111 at 0x8 and DRAM write 0x22222222 at DRAM_BASE+0x8 -> each bank reads back its own value; the other bank is unaffected.
